// File: rtl/lbp_pkg.sv
// Shared definitions for the local branch predictor: sweep FSM states,
// saturating-counter constants and PC tag/index slicing helpers.
package lbp_pkg;

  // Sweep-invalidate controller states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } lbp_state_e;

  // Reset value of a PHT counter: weakly not-taken (MSB clear, one below the midpoint).
  function automatic int unsigned ctr_init(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

  // Saturation ceiling of a PHT counter.
  function automatic int unsigned ctr_max(input int unsigned ctr_bits);
    return (32'd1 << ctr_bits) - 32'd1;
  endfunction

  // Table index: word-aligned PC bits just above the byte offset.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  // Tag: every PC bit above the index.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/lbp_sat_counter.sv
// Combinational next-state for a CTR_BITS-wide saturating up/down counter.
// Holds at zero when decrementing and at all-ones when incrementing.
module lbp_sat_counter
  import lbp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur,
  input  logic                inc,
  output logic [CTR_BITS-1:0] nxt
);

  localparam logic [CTR_BITS-1:0] CTR_TOP = CTR_BITS'(ctr_max(CTR_BITS));

  // Step toward the requested direction unless already pinned at that end.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    nxt = cur;
    if (inc) begin
      if (cur != CTR_TOP) nxt = cur + CTR_BITS'(1);
    end else begin
      if (cur != '0) nxt = cur - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/local_bpred_table.sv
// Two-level local branch predictor with a tagged BTB.
// Fetch looks up combinationally; decode trains LHT, shared PHT and BTB.
// A sweep FSM clears every BTB valid bit, one entry per cycle, on inval_req.
// Optional build macro LBP_STATS_EN adds update / mispredict counters.
module local_bpred_table
  import lbp_pkg::*;
#(
  parameter int IDX_BITS  = 4,
  parameter int HIST_BITS = 4,
  parameter int CTR_BITS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        found,
  output logic        bpredsel,
  output logic [31:0] bta,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        inval_req,
  output logic        busy
`ifdef LBP_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispred
`endif
);

  localparam int ENTRIES   = 2 ** IDX_BITS;
  localparam int PHT_DEPTH = 2 ** HIST_BITS;
  localparam int TAG_BITS  = 30 - IDX_BITS;
  localparam logic [CTR_BITS-1:0]  CTR_RST  = CTR_BITS'(ctr_init(CTR_BITS));
  localparam logic [IDX_BITS-1:0]  PTR_LAST = '1;
  localparam logic [HIST_BITS-1:0] HIST_ONE = HIST_BITS'(1);

  logic                 valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [HIST_BITS-1:0] lht_q    [ENTRIES];
  logic [CTR_BITS-1:0]  pht_q    [PHT_DEPTH];
  lbp_state_e           state_q;
  logic [IDX_BITS-1:0]  ptr_q;

  // Fetch-side lookup: pure function of the registered tables.
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic [CTR_BITS-1:0] lk_ctr;

  assign lk_idx   = IDX_BITS'(pc_index(lookup_pc, IDX_BITS));
  assign lk_tag   = TAG_BITS'(pc_tag(lookup_pc, IDX_BITS));
  assign lk_hit   = (state_q == IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_ctr   = pht_q[lht_q[lk_idx]];
  assign found    = lk_hit;
  assign bpredsel = lk_hit & lk_ctr[CTR_BITS-1];
  assign bta      = lk_hit ? target_q[lk_idx] : 32'd0;
  assign busy     = (state_q == SWEEP);

  // Decode-side training inputs, all taken from pre-update state.
  logic [IDX_BITS-1:0]  u_idx;
  logic [TAG_BITS-1:0]  u_tag;
  logic                 u_hit;
  logic                 u_en;
  logic [HIST_BITS-1:0] u_hist;
  logic [CTR_BITS-1:0]  u_ctr;
  logic [CTR_BITS-1:0]  u_ctr_nxt;

  assign u_idx  = IDX_BITS'(pc_index(upd_pc, IDX_BITS));
  assign u_tag  = TAG_BITS'(pc_tag(upd_pc, IDX_BITS));
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_en   = upd_valid && (state_q == IDLE);
  assign u_hist = lht_q[u_idx];
  assign u_ctr  = pht_q[u_hist];

  lbp_sat_counter #(.CTR_BITS(CTR_BITS)) u_sat (
    .cur (u_ctr),
    .inc (upd_taken),
    .nxt (u_ctr_nxt)
  );

  // Table state: reset, sweep clearing of valid bits, and branch training.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the tables are flop arrays with a defined reset image, so every entry is reset explicitly.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        lht_q[i]    <= '0;
      end
      for (int j = 0; j < PHT_DEPTH; j++) pht_q[j] <= CTR_RST;
    end else if (state_q == SWEEP) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (u_en) begin
      // NOTE: non-blocking assignments so every read above sees pre-edge state.
      pht_q[u_hist] <= u_ctr_nxt;
      if (u_hit) begin
        lht_q[u_idx] <= {u_hist[HIST_BITS-2:0], upd_taken};
        if (upd_taken) target_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        lht_q[u_idx]    <= HIST_ONE;
      end
    end
  end

  // Sweep controller: walks ptr over every entry once, then returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else if (state_q == IDLE) begin
      ptr_q <= '0;
      if (inval_req) state_q <= SWEEP;
    end else begin
      ptr_q <= ptr_q + IDX_BITS'(1);
      if (ptr_q == PTR_LAST) state_q <= IDLE;
    end
  end

`ifdef LBP_STATS_EN
  logic u_pred;
  assign u_pred = u_hit & u_ctr[CTR_BITS-1];

  // Accepted-update and wrong-direction counters; wrap naturally at 2**32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else if (u_en) begin
      stat_lookups <= stat_lookups + 32'd1;
      if (u_pred != upd_taken) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule
